// File: rtl/aes_out_serializer.sv
// rtl/aes_out_serializer.sv - two-block ciphertext buffer emitting one byte per transfer
// Optional out_last port is enabled by defining AES_SER_LAST_EN.
module aes_out_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
`ifdef AES_SER_LAST_EN
  output logic         out_last,
`endif
  output logic         overflow
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t       state_q, state_d;
  logic [127:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic [3:0]   idx_q, idx_d;
  logic         ovf_q, ovf_d;
  logic         xfer, pop, push;
  logic [3:0]   byte_sel;
  logic [127:0] head;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    xfer     = (state_q == S_SEND) && out_ready;
    pop      = xfer && (idx_q == 4'hF);
    // A full FIFO still accepts when the head finishes on the same edge.
    push     = blk_valid && ((count_q != 2'd2) || pop);

    if (xfer) idx_d = idx_q + 4'd1;
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (blk_valid && !push) ovf_d = 1'b1;
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: if (push) state_d = S_SEND;
      S_SEND: if (pop && (count_d == 2'd0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      idx_q    <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= blk_data;
  end

  // Byte 15 of the block lives in bits [127:120], so MSB-first walks indices downward.
  assign byte_sel  = MSB_FIRST ? ~idx_q : idx_q;
  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (state_q == S_SEND);
  assign out_data  = out_valid ? head[{byte_sel, 3'b000} +: 8] : 8'h00;
  assign busy      = (count_q != 2'd0);
  assign overflow  = ovf_q;
`ifdef AES_SER_LAST_EN
  assign out_last  = out_valid && (idx_q == 4'hF);
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// tb/tb_aes_out_serializer.sv - scoreboard bench for both byte orders of aes_out_serializer
module tb_aes_out_serializer;

  logic         clk = 1'b0;
  logic         rst, blk_valid, out_ready;
  logic [127:0] blk_data;
  logic [7:0]   m_data, l_data;
  logic         m_valid, l_valid, m_busy, l_busy, m_ovf, l_ovf;
`ifdef AES_SER_LAST_EN
  logic         m_last, l_last;
`endif

  always #5 clk = ~clk;

  aes_out_serializer #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_data(blk_data),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready), .busy(m_busy),
`ifdef AES_SER_LAST_EN
    .out_last(m_last),
`endif
    .overflow(m_ovf));

  aes_out_serializer #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_data(blk_data),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready), .busy(l_busy),
`ifdef AES_SER_LAST_EN
    .out_last(l_last),
`endif
    .overflow(l_ovf));

  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  int         pending = 0;
  bit         ovf_model = 1'b0;
  logic [7:0] expm[$];
  logic [7:0] expl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes still owed decide how many blocks occupy the two slots.
  always @(posedge clk) begin
    if (rst) begin
      pending = 0;
      ovf_model = 1'b0;
      expm.delete();
      expl.delete();
    end else begin
      if (pending > 0 && out_ready) pending--;
      if (blk_valid) begin
        if ((pending + 15) / 16 < 2) begin
          pending += 16;
          for (int k = 0; k < 16; k++) begin
            expm.push_back(blk_data[127 - 8*k -: 8]);
            expl.push_back(blk_data[8*k +: 8]);
          end
        end else begin
          ovf_model = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid_m", m_valid, pending > 0);
      chk("valid_l", l_valid, pending > 0);
      chk("busy", {m_busy, l_busy}, {2{pending > 0}});
      chk("overflow", {m_ovf, l_ovf}, {2{ovf_model}});
`ifdef AES_SER_LAST_EN
      chk("last_m", m_last, (pending > 0) && (pending % 16 == 1));
      chk("last_l", l_last, (pending > 0) && (pending % 16 == 1));
`endif
      if (m_valid || l_valid) begin
        if (expm.size() == 0) begin
          errors++;
          $display("FAIL data: output valid with no expected byte at %0t", $time);
        end else begin
          chk("data_m", m_data, expm[0]);
          chk("data_l", l_data, expl[0]);
          if (out_ready) begin
            void'(expm.pop_front());
            void'(expl.pop_front());
          end
        end
      end else begin
        chk("idle_data", {m_data, l_data}, 16'h0000);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [127:0] d);
    blk_valid = 1'b1;
    blk_data  = d;
    cyc();
    blk_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    t = 0;
    while (pending > 0 && t < 200) begin
      cyc();
      t++;
    end
    chk("drain_timeout", pending, 0);
    cyc(2);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] FIPS = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    rst = 1'b1; blk_valid = 1'b0; out_ready = 1'b0; blk_data = '0;
    cyc();
    mon_en = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    out_ready = 1'b1;
    pulse(FIPS);
    cyc(20);

    pulse(FIPS);
    for (int i = 0; i < 80 && pending > 0; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      cyc();
    end
    drain();

    out_ready = 1'b0;
    pulse(rnd128()); cyc();
    pulse(rnd128()); cyc();
    pulse(rnd128()); cyc(4);
    chk("ovf_set", m_ovf, 1'b1);
    drain();

    rst = 1'b1; cyc(); rst = 1'b0;
    out_ready = 1'b1;
    pulse(rnd128());
    pulse(rnd128());
    cyc(14);
    pulse(rnd128());
    chk("no_ovf_simul", m_ovf, 1'b0);
    drain();

    pulse(FIPS);
    cyc(5);
    rst = 1'b1; blk_valid = 1'b1; blk_data = rnd128();
    cyc();
    rst = 1'b0; blk_valid = 1'b0;
    cyc(2);
    pulse(FIPS);
    drain();

    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      blk_valid = ($urandom_range(0, 9) == 0);
      blk_data  = rnd128();
      cyc();
    end
    blk_valid = 1'b0;
    drain();
    chk("queue_empty", expm.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
